// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit adder slice reused per clock,
// walking WIDTH-bit operands LSB-first with the carry held in a flop between digits.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE); while
  // busy=1 start is ignored. done pulses for one cycle with sum/carry/overflow valid,
  // and those results hold until the next completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dovf, last, load;

  // Digit slice; the carry into the digit MSB is recovered as a^b^s at that bit.
  always_comb begin
    {dcout, dsum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
    dovf    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dcout;
    res_nxt = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    last    = (cnt_q == CW'(K - 1));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // Subtract is A + ~B + 1; cin only matters for add.
      a_q   <= in1;
      b_q   <= sub ? ~in2 : in2;
      cy_q  <= sub ? 1'b1 : cin;
      res_q <= '0;
      cnt_q <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      res_q <= res_nxt;
      cy_q  <= dcout;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        sum      <= res_nxt;
        carry    <= dcout;
        overflow <= dovf;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: an 8-bit bit-serial instance and a 16-bit
// instance processing 4-bit digits, sharing clock and reset.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] in1_8 = '0, in2_8 = '0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] in1_16 = '0, in2_16 = '0;
  logic        busy16, done16, carry16, ovf16;
  logic [15:0] sum16;

  int n_vec = 0;
  int n_err = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in1(in1_8), .in2(in2_8),
    .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .sum(sum8),
    .carry(carry8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .in1(in1_16), .in2(in2_16),
    .cin(cin16), .sub(sub16), .busy(busy16), .done(done16), .sum(sum16),
    .carry(carry16), .overflow(ovf16)
  );

  // Drive one 8-bit op and wait (bounded) for done. disturb: 0 none,
  // 1 toggle cin mid-run, 2 re-pulse start and scramble all inputs mid-run.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sb, input int disturb, output int lat,
                        output logic busy_ok);
    @(negedge clk);
    start8 = 1'b1; in1_8 = a; in2_8 = b; cin8 = ci; sub8 = sb;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      if (done8) break;
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (disturb == 1) cin8 = ~cin8;
      if (disturb == 2) begin
        start8 = 1'b1;
        in1_8 = 8'($urandom_range(0, 255));
        in2_8 = 8'($urandom_range(0, 255));
        cin8 = 1'($urandom_range(0, 1));
        sub8 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'h0) begin
      n_err++;
      $display("FAIL reset8 got busy=%b done=%b sum=%h c=%b v=%b want all 0", busy8, done8, sum8, carry8, ovf8);
    end
    n_vec++;
    if ({busy16, done16, sum16, carry16, ovf16} !== 20'h0) begin
      n_err++;
      $display("FAIL reset16 got busy=%b done=%b sum=%h c=%b v=%b want all 0", busy16, done16, sum16, carry16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add_zero();
    int lat;
    logic bok;
    do_op8(8'h00, 8'h00, 1'b0, 1'b0, 0, lat, bok);
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL zero_latency got %0d want 8", lat); end
    n_vec++;
    if (bok !== 1'b1) begin n_err++; $display("FAIL zero_busy_run got busy low during run want high"); end
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h00, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL zero_result got sum=%h c=%b v=%b want 00 0 0", sum8, carry8, ovf8);
    end
    n_vec++;
    if (busy8 !== 1'b0) begin n_err++; $display("FAIL zero_busy_done got %b want 0", busy8); end
    @(posedge clk); #1;
    n_vec++;
    if ({busy8, done8} !== 2'b00) begin n_err++; $display("FAIL zero_idle got busy/done=%b%b want 00", busy8, done8); end
  endtask

  task automatic test_carry_overflow();
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'hFF};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [9:0] te [3] = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1}, {8'hFF, 1'b1, 1'b0}};
    int lat;
    logic bok;
    for (int i = 0; i < 3; i++) begin
      do_op8(ta[i], tb[i], tc[i], 1'b0, 0, lat, bok);
      n_vec++;
      if ({sum8, carry8, ovf8} !== te[i] || lat !== 8) begin
        n_err++;
        $display("FAIL add_%0d got sum=%h c=%b v=%b lat=%0d want %h %b %b lat=8",
                 i, sum8, carry8, ovf8, lat, te[i][9:2], te[i][1], te[i][0]);
      end
    end
  endtask

  task automatic test_subtract();
    int lat;
    logic bok;
    do_op8(8'h05, 8'h07, 1'b0, 1'b1, 1, lat, bok);
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL sub_05_07 got sum=%h c=%b v=%b want fe 0 0", sum8, carry8, ovf8);
    end
    do_op8(8'h80, 8'h01, 1'b1, 1'b1, 1, lat, bok);
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL sub_80_01 got sum=%h c=%b v=%b want 7f 1 1", sum8, carry8, ovf8);
    end
  endtask

  task automatic test_ignore_midrun();
    int lat;
    logic bok;
    do_op8(8'h3C, 8'h5A, 1'b0, 1'b0, 2, lat, bok);
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h96, 1'b0, 1'b1} || lat !== 8 || bok !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_midrun got sum=%h c=%b v=%b lat=%0d busy_ok=%b want 96 0 1 lat=8 busy_ok=1",
               sum8, carry8, ovf8, lat, bok);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bok;
    do_op8(8'h12, 8'h34, 1'b0, 1'b0, 0, lat, bok);
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h46, 1'b0, 1'b0} || done8 !== 1'b1) begin
      n_err++; $display("FAIL b2b_first got sum=%h c=%b v=%b done=%b want 46 0 0 done=1", sum8, carry8, ovf8, done8);
    end
    // Still in the DONE cycle: request the next op right away.
    start8 = 1'b1; in1_8 = 8'hC8; in2_8 = 8'h38; cin8 = 1'b0; sub8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_vec++;
    if ({busy8, done8} !== 2'b10) begin
      n_err++; $display("FAIL b2b_no_idle got busy/done=%b%b want 10", busy8, done8);
    end
    lat = 0;
    while (lat < 40 && done8 !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h90, 1'b1, 1'b0} || lat !== 8) begin
      n_err++; $display("FAIL b2b_second got sum=%h c=%b v=%b lat=%0d want 90 1 0 lat=8", sum8, carry8, ovf8, lat);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic bok;
    logic seen_done;
    @(negedge clk);
    start8 = 1'b1; in1_8 = 8'h55; in2_8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'h0) begin
      n_err++;
      $display("FAIL async_reset got busy=%b done=%b sum=%h c=%b v=%b want all 0", busy8, done8, sum8, carry8, ovf8);
    end
    #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done got activity=1 want 0"); end
    do_op8(8'h10, 8'h20, 1'b0, 1'b0, 0, lat, bok);
    n_vec++;
    if ({sum8, carry8, ovf8} !== {8'h30, 1'b0, 1'b0} || lat !== 8) begin
      n_err++; $display("FAIL after_reset got sum=%h c=%b v=%b lat=%0d want 30 0 0 lat=8", sum8, carry8, ovf8, lat);
    end
  endtask

  task automatic test_digit4();
    int lat;
    @(negedge clk);
    start16 = 1'b1; in1_16 = 16'h1234; in2_16 = 16'hEDCC; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (lat < 40 && done16 !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL d4_latency got %0d want 4", lat); end
    n_vec++;
    if ({sum16, carry16, ovf16} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL d4_result got sum=%h c=%b v=%b want 0000 1 0", sum16, carry16, ovf16);
    end
  endtask

  initial begin
    test_reset();
    test_add_zero();
    test_carry_overflow();
    test_subtract();
    test_ignore_midrun();
    test_back_to_back();
    test_async_reset();
    test_digit4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor built around one DIGIT-bit full-adder slice, reused once per clock.
- Processes WIDTH-bit operands LSB-first, DIGIT bits per cycle, and carries the carry between cycles in a flip-flop.
- Handshake is start/busy/done.
- Successor to the single-bit full adder. Intended as the area-cheap arithmetic unit for datapath blocks with no single-cycle add requirement.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH. Elaboration fails otherwise.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request; sampled only when not busy.
- in1, in, WIDTH, operand A; captured when start is accepted.
- in2, in, WIDTH, operand B; captured when start is accepted.
- cin, in, 1, carry-in for add; ignored when sub=1. Captured at start.
- sub, in, 1, 0 = add, 1 = subtract; captured at start.
- busy, out, 1, high while an operation is in progress.
- done, out, 1, one-cycle pulse; results valid.
- sum, out, WIDTH, result.
- carry, out, 1, final carry-out. For sub, 1 means no borrow.
- overflow, out, 1, two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0.
  - Internal operand/shift registers, carry flop and digit counter all cleared.
- States:
  - IDLE: start=1 at a clock edge → load operands and go to RUN. Otherwise stay.
  - RUN: on each edge, add the lowest DIGIT bits of the A/B shift registers plus the carry flop. Shift the result digit into the result register from the MSB side, shift A/B right by DIGIT, store the carry-out, and increment the counter. On the edge processing digit K-1 (K = WIDTH/DIGIT), go to DONE.
  - DONE: lasts exactly one cycle. start=1 → load and go to RUN (back-to-back). Else → IDLE.
- Operand load:
  - A ← in1.
  - sub=0: B ← in2, carry flop ← cin.
  - sub=1: B ← ~in2, carry flop ← 1, so sum = in1 − in2.
- Latency:
  - The start-accepting edge is edge 0; done is high in the cycle following edge K. Latency = K cycles (WIDTH=16, DIGIT=1 → 16).
- Outputs per state:
  - busy = 1 in RUN only; busy = 0 in IDLE and DONE.
  - done = 1 in DONE only.
- Result registers:
  - sum, carry and overflow are registered and updated only on the edge entering DONE.
  - Values are held until the next completion or reset, and never show partial results.
- Overflow = carry into the MSB XOR carry out of the MSB. Captured from the final digit's internal carries.
- start while busy=1 is ignored; no queueing.
- Changes on in1/in2/cin/sub after the start-accepting edge do not affect the result in progress.
- rst_n asserted mid-RUN: immediate abort to reset values; no done pulse. First start after release behaves as from IDLE.
- Arithmetic is modulo 2^WIDTH; carry holds bit WIDTH.

Test Plan (WIDTH=8 unless noted):
- Add 0x00+0x00, cin=0 → done exactly 8 cycles after start edge; sum=0x00, carry=0, overflow=0. busy=1 for 8 cycles, then 0.
- Carry/overflow boundaries:
  - 0xFF+0x01, cin=0 → sum=0x00, carry=1, overflow=0.
  - 0x7F+0x01 → sum=0x80, carry=0, overflow=1.
  - 0xFF+0xFF, cin=1 → sum=0xFF, carry=1.
- Subtract:
  - 0x05−0x07 → sum=0xFE, carry=0, overflow=0.
  - 0x80−0x01 → sum=0x7F, carry=1, overflow=1.
  - cin toggled during these ops has no effect.
- Handshake:
  - start re-pulsed and in1/in2 changed mid-RUN → ignored; original result returned.
  - start held high in the DONE cycle → second op begins with no IDLE cycle; its done arrives 8 cycles later.
- rst_n pulsed low for 2 ns at RUN cycle 3 (asynchronous, between edges) → busy/done/sum/carry/overflow go to 0 immediately and no done follows. A subsequent 0x10+0x20 gives 0x30.
- WIDTH=16, DIGIT=4: 0x1234+0xEDCC, cin=0 → done 4 cycles after start; sum=0x0000, carry=1, overflow=0.
